// File: rtl/fu_seq_alu.sv
// fu_seq_alu: small sequential ALU with single-cycle arithmetic/logic ops and
// multi-cycle shifts/rotates that move one bit per clock.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, op, A, B, sh request, 4-bit opcode, operands, shift amount
//   busy               high while a multi-cycle shift/rotate is running
//   done               one-cycle pulse when R and the flags are updated
//   R, C, V, N, Z      registered result and status flags
//
// Build option: define FU_ROTATE_EN to enable ROL (10) / ROR (11).
// Without it those opcodes are treated as illegal and no rotate logic exists.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete from here
// RUN   | shifting the working register one bit per clock
module fu_seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   sh,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_NEG  = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_MOD  = 4'd9;
`ifdef FU_ROTATE_EN
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] work, step, res;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic             step_out, res_c, res_v, is_multi;
  logic [WIDTH:0]   sum;

  always_comb begin
    is_multi = (op == OP_SHL) || (op == OP_ASR);
`ifdef FU_ROTATE_EN
    if ((op == OP_ROL) || (op == OP_ROR)) is_multi = 1'b1;
`endif
  end

  // Single-cycle result and carry/overflow; illegal opcodes fall to zero.
  always_comb begin
    sum   = '0;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, A} + {1'b0, B};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        res   = sum[WIDTH-1:0];
        res_c = ~sum[WIDTH];  // borrow
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_INC: begin
        sum   = {1'b0, A} + (WIDTH+1)'(1);
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OP_NEG: begin
        res   = ~A + WIDTH'(1);
        res_c = (A == '0);
        res_v = (A == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_NAND: res = ~(A & B);
      OP_XNOR: res = ~(A ^ B);
      OP_NOT:  res = ~A;
      OP_MOD:  res = B & ~({WIDTH{1'b1}} << sh);
      default: res = '0;
    endcase
  end

  // One-bit move of the working register for the captured opcode.
  always_comb begin
    step     = work;
    step_out = 1'b0;
    case (op_q)
      OP_SHL: begin
        step     = {work[WIDTH-2:0], 1'b0};
        step_out = work[WIDTH-1];
      end
      OP_ASR: begin
        step     = {work[WIDTH-1], work[WIDTH-1:1]};
        step_out = work[0];
      end
`ifdef FU_ROTATE_EN
      OP_ROL: begin
        step     = {work[WIDTH-2:0], work[WIDTH-1]};
        step_out = work[WIDTH-1];
      end
      OP_ROR: begin
        step     = {work[0], work[WIDTH-1:1]};
        step_out = work[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A zero shift amount completes straight from IDLE, so RUN always has cnt >= 1.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && is_multi && (sh != '0)) state_nxt = S_RUN;
      S_RUN:  if (cnt == SHW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
      op_q <= '0;
      done <= 1'b0;
      R    <= '0;
      C    <= 1'b0;
      V    <= 1'b0;
      N    <= 1'b0;
      Z    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          if (is_multi && (sh != '0)) begin
            work <= B;
            cnt  <= sh;
            op_q <= op;
          end else if (is_multi) begin
            done <= 1'b1;
            R    <= B;
            C    <= 1'b0;
            V    <= 1'b0;
            N    <= B[WIDTH-1];
            Z    <= (B == '0);
          end else begin
            done <= 1'b1;
            R    <= res;
            C    <= res_c;
            V    <= res_v;
            N    <= res[WIDTH-1];
            Z    <= (res == '0);
          end
        end
      end else begin
        work <= step;
        cnt  <= cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          done <= 1'b1;
          R    <= step;
          C    <= step_out;
          V    <= 1'b0;
          N    <= step[WIDTH-1];
          Z    <= (step == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_seq_alu.sv
module tb_fu_seq_alu;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [3:0]     op_i = '0;
  logic [W-1:0]   a_i = '0, b_i = '0;
  logic [SHW-1:0] sh_i = '0;
  logic           busy, done, C, V, N, Z;
  logic [W-1:0]   R;

  int n_chk  = 0;
  int n_pass = 0;

  fu_seq_alu #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .A(a_i), .B(b_i), .sh(sh_i),
    .busy(busy), .done(done), .R(R), .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic longint sgn(input longint x);
    return (x >= (64'sd1 << (W-1))) ? x - (64'sd1 << W) : x;
  endfunction

  // Reference computed from the opcode definitions with plain integer arithmetic.
  function automatic void model(input int op, input longint a, input longint b, input int s,
                                output longint r, output longint c, output longint v,
                                output int lat, output int nbusy);
    longint mask = (64'sd1 << W) - 1;
    longint t;
    bit multi = 0;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin t = a + b; r = t & mask; c = t >> W;
               t = sgn(a) + sgn(b); v = (t > 127 || t < -128); end
      1: begin r = (a - b) & mask; c = (a < b);
               t = sgn(a) - sgn(b); v = (t > 127 || t < -128); end
      2: begin t = a + 1; r = t & mask; c = t >> W; v = (sgn(a) + 1 > 127); end
      3: begin r = (-a) & mask; c = (a == 0); v = (-sgn(a) > 127); end
      4: r = ~(a & b) & mask;
      5: r = ~(a ^ b) & mask;
      6: r = ~a & mask;
      7: begin multi = 1; r = (b << s) & mask; c = (s > 0) ? (b >> (W - s)) & 1 : 0; end
      8: begin multi = 1; t = sgn(b); r = (t >>> s) & mask;
               c = (s > 0) ? (b >> (s - 1)) & 1 : 0; end
      9: r = b & ((64'sd1 << s) - 1);
`ifdef FU_ROTATE_EN
      10: begin multi = 1; r = ((b << s) | (b >> (W - s))) & mask; c = (s > 0) ? r & 1 : 0; end
      11: begin multi = 1; r = ((b >> s) | (b << (W - s))) & mask;
                c = (s > 0) ? (r >> (W - 1)) & 1 : 0; end
`endif
      default: ;
    endcase
    lat   = multi ? s + 1 : 1;
    nbusy = multi ? s : 0;
  endfunction

  // Called at a negedge. garbage=1 keeps start high with random inputs while busy.
  task automatic do_op(input int o, input int a, input int b, input int s, input bit garbage);
    longint er, ec, ev;
    int elat, ebusy, lat, nb;
    bit got;
    model(o, a, b, s, er, ec, ev, elat, ebusy);
    op_i = 4'(o); a_i = W'(a); b_i = W'(b); sh_i = SHW'(s); start = 1'b1;
    lat = 0; nb = 0; got = 0;
    while (lat < 40 && !got) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (done) got = 1;
      else begin
        if (busy) nb++;
        start = garbage;
        if (garbage) begin
          op_i = 4'($urandom_range(0, 15)); a_i = W'($urandom); b_i = W'($urandom);
          sh_i = SHW'($urandom);
        end
      end
    end
    start = 1'b0;
    check($sformatf("done_seen op%0d", o), got, 1);
    check($sformatf("latency op%0d", o), lat, elat);
    check($sformatf("busy_cycles op%0d", o), nb, ebusy);
    check($sformatf("R op%0d a%0h b%0h s%0d", o, a, b, s), R, er);
    check($sformatf("C op%0d", o), C, ec);
    check($sformatf("V op%0d", o), V, ev);
    check($sformatf("N op%0d", o), N, (er >> (W - 1)) & 1);
    check($sformatf("Z op%0d", o), Z, er == 0);
    @(posedge clk); @(negedge clk);
    check($sformatf("done_pulse op%0d", o), done, 0);
    check($sformatf("R_hold op%0d", o), R, er);
  endtask

  initial begin
    int ndone;
    #2;
    check("rst_R", R, 0);
    check("rst_flags", {C, V, N, Z}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    do_op(0, 8'h7F, 8'h01, 0, 0);
    do_op(1, 8'h00, 8'h01, 0, 0);
    do_op(3, 8'h80, 8'h00, 0, 0);
    do_op(3, 8'h00, 8'h00, 0, 0);
    do_op(2, 8'h7F, 8'h00, 0, 0);
    do_op(8, 8'h00, 8'h90, 4, 1);
    do_op(10, 8'h00, 8'h81, 1, 0);
    do_op(11, 8'h00, 8'h81, 3, 1);
    do_op(7, 8'h00, 8'hC3, 0, 0);
    do_op(7, 8'h00, 8'hFF, 7, 1);
    do_op(13, 8'h12, 8'h34, 2, 0);

    // Back-to-back: a start in the done cycle is accepted.
    op_i = 4'd0; a_i = 8'h10; b_i = 8'h22; sh_i = '0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("b2b_done1", done, 1);
    check("b2b_R1", R, 8'h32);
    op_i = 4'd1; a_i = 8'h05; b_i = 8'h07;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("b2b_done2", done, 1);
    check("b2b_R2", R, 8'hFE);
    check("b2b_C2", C, 1);

    for (int i = 0; i < 60; i++)
      do_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, W - 1), 1'($urandom));

    // Reset in the middle of a shift aborts it.
    do_op(0, 8'h7F, 8'h01, 0, 0);
    op_i = 4'd7; b_i = 8'h01; sh_i = 3'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("abort_R", R, 0);
    check("abort_flags", {C, V, N, Z}, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_R_kept", R, 0);
    do_op(9, 8'h00, 8'hAB, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fu_seq_alu.md
FU_SEQ_ALU -- requirements
Module: fu_seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal values 4..32).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width in bits.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  4  opcode; the encoding is defined in REQ-012.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand; this is the shift source for the shift/mod opcodes.
REQ-009 sh  input  SHW  shift amount, from 0 to WIDTH-1.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 done  output  1  one-cycle pulse; R, C, V, N and Z are valid from this cycle onward.
REQ-011a R  output  WIDTH  result; C, V, N, Z  output  1 each  status flags, all registered.

Function
REQ-012 The opcode map SHALL be:
- 0 ADD A+B
- 1 SUB A-B
- 2 INC A+1
- 3 NEG -A
- 4 NAND
- 5 XNOR
- 6 NOT A
- 7 SHL B by sh, logical
- 8 ASR B by sh
- 9 MOD B&(2^sh-1)
- 10 ROL B by sh
- 11 ROR B by sh
- 12-15 illegal

REQ-013 FSM states SHALL be IDLE and RUN.
- IDLE + start + single-cycle op (0-6, 9, illegal): compute, register R and flags, pulse done next cycle, remain in IDLE.
- IDLE + start + op 7/8/10/11: capture B and sh, load the counter with sh, and enter RUN.

REQ-014 RUN SHALL shift the working register one bit per cycle and decrement the counter. When the counter reaches 0, the block writes R and flags, pulses done and returns to IDLE. Latency from the start edge to done is sh+1 cycles; sh=0 gives latency 1 and R=B.
REQ-015 busy SHALL be 1 exactly while in RUN. start is ignored while busy=1. A start in the done cycle is accepted.
REQ-016 R and the flags SHALL hold their values until the next done or reset.
REQ-017 ADD: C is the carry-out. V is 1 when the operands have the same sign and the result sign differs.
REQ-018 SUB: computed as A+~B+1. C is the borrow, equal to the inverted carry-out. V is the signed overflow.
REQ-019 INC: C is the carry-out; V=1 iff A=0111..1.
REQ-019a NEG: C=1 iff A=0; V=1 iff A=1000..0.
REQ-020 NAND, XNOR, NOT, MOD: C=0, V=0.
REQ-020a Shifts and rotates: C is the last bit shifted or rotated out (0 when sh=0), and V=0.
REQ-020b ASR replicates the sign bit B[WIDTH-1]. SHL fills with zeros. Rotates wrap the bit shifted out back into the opposite end.
REQ-021 For every opcode, N=R[WIDTH-1] and Z=(R==0).
REQ-022 Illegal opcodes SHALL give R=0, C=V=N=0, Z=1 and done with latency 1.

Reset
REQ-023 While rst=1, the block SHALL immediately force IDLE, R=0, C=V=N=Z=0, busy=0, done=0 and counter=0, regardless of clk.
REQ-024 Reset during RUN SHALL abort the operation: no done pulse, and R keeps its reset value.
REQ-024a The first start sampled on a clk edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 The macro FU_ROTATE_EN SHALL select the rotate opcodes.
- Defined: opcodes 10 and 11 behave per REQ-012/014/020.
- Undefined: opcodes 10 and 11 are illegal (REQ-022), and no rotate datapath is synthesised.

Verification (WIDTH=8)
REQ-026 ADD A=0x7F B=0x01 -> done 1 cycle after start; R=0x80, C=0, V=1, N=1, Z=0; busy stays 0.
REQ-027 SUB A=0x00 B=0x01 -> R=0xFF, C=1, V=0, N=1. NEG A=0x80 -> R=0x80, V=1, C=0. NEG A=0x00 -> R=0x00, C=1, Z=1.
REQ-028 ASR B=0x90 sh=4 -> busy high 4 cycles, done on cycle 5; R=0xF9, C=0, N=1. A start issued during busy is ignored.
REQ-029 ROL B=0x81 sh=1 with FU_ROTATE_EN -> R=0x03, C=1, done at cycle 2. Without the macro -> R=0x00, Z=1, done at cycle 1.
REQ-030 SHL B=0x01 sh=7, rst asserted at cycle 3 -> outputs 0 immediately, no done. Then MOD B=0xAB sh=4 -> R=0x0B, N=0, done at cycle 1.
